// File: rtl/mips_pkg.sv
// Shared types and constants for the instruction-memory loader: FSM state encoding,
// byte/word geometry and a state-decode helper.
package mips_pkg;

    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = BYTE_W * BYTES_PER_WORD;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEN     = 3'd1,
        COLLECT = 3'd2,
        WRITE   = 3'd3,
        CHK     = 3'd4,
        DONE    = 3'd5,
        ERROR   = 3'd6
    } loader_state_t;

    // States in which the loader offers Byte_ready to the byte source.
    function automatic logic accepts_bytes(input loader_state_t s);
        case (s)
            LEN, COLLECT, CHK: accepts_bytes = 1'b1;
            default:           accepts_bytes = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/instr_mem_loader_word_assembler.sv
// Big-endian word assembler: shifts bytes in MSB-first and flags the 4th byte of each word.
// word_next exposes the value the register takes at the coming edge so the caller can latch it.
module word_assembler
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              shift_en,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word_next,
    output logic              word_full
);

    logic [WORD_W-1:0] word_q, word_d;
    logic [1:0]        cnt_q, cnt_d;

    // Next shift-register and byte-count values.
    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (clear) begin
            word_d = {WORD_W{1'b0}};
            cnt_d  = 2'd0;
        end else if (shift_en) begin
            word_d = {word_q[WORD_W-BYTE_W-1:0], byte_in};
            cnt_d  = cnt_q + 2'd1;
        end else begin
            word_d = word_q;
            cnt_d  = cnt_q;
        end
    end

    // The count wraps naturally, so the next word starts at byte 0 without an explicit clear.
    always_comb begin
        word_next = word_d;
        word_full = shift_en && !clear && (cnt_q == 2'd3);
    end

    // Shift register and byte counter state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_q <= {WORD_W{1'b0}};
            cnt_q  <= 2'd0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Byte-stream loader for instruction memory: length byte, then big-endian words written to
// consecutive word addresses while the CPU is held. Optional trailing XOR checksum: CHECKSUM_EN.
module instr_mem_loader
    import mips_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WORDS  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  Start,
    input  logic [BYTE_W-1:0]     Byte_in,
    input  logic                  Byte_valid,
    output logic                  Byte_ready,
    output logic [ADDR_WIDTH-1:0] Write_address,
    output logic [DATA_WIDTH-1:0] Write_data,
    output logic                  Mem_write,
    output logic                  Cpu_hold,
    output logic                  Done,
    output logic                  Error
);

    localparam int IDX_W = $clog2(NUM_WORDS + 1);

    loader_state_t state_q, state_d;

    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [BYTE_W-1:0]     n_q, n_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  byte_ready_q, byte_ready_d;
    logic                  mem_write_q, mem_write_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  cpu_hold_q, cpu_hold_d;

    logic              xfer_s;
    logic              len_bad_s;
    logic              last_word_s;
    logic              asm_clear_s;
    logic              asm_shift_s;
    logic [WORD_W-1:0] word_next_s;
    logic              word_full_s;

`ifdef CHECKSUM_EN
    logic [BYTE_W-1:0] csum_q, csum_d;
    logic              csum_ok_s;
`endif

    word_assembler u_asm (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (asm_clear_s),
        .shift_en  (asm_shift_s),
        .byte_in   (Byte_in),
        .word_next (word_next_s),
        .word_full (word_full_s)
    );

    // Handshake and decode terms shared by the FSM and datapath.
    always_comb begin
        xfer_s      = Byte_valid && byte_ready_q;
        len_bad_s   = (Byte_in == 8'd0) || ({1'b0, Byte_in} > 9'(NUM_WORDS));
        last_word_s = (8'(idx_q) == (n_q - 8'd1));
        asm_clear_s = (state_d == LEN) && (state_q != LEN);
        asm_shift_s = (state_q == COLLECT) && xfer_s;
`ifdef CHECKSUM_EN
        csum_ok_s   = (Byte_in == csum_q);
`endif
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; Start only matters in IDLE, DONE and ERROR.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (Start) state_d = LEN;
                else       state_d = IDLE;
            end
            LEN: begin
                if (xfer_s) state_d = len_bad_s ? ERROR : COLLECT;
                else        state_d = LEN;
            end
            COLLECT: begin
                if (word_full_s) state_d = WRITE;
                else             state_d = COLLECT;
            end
            WRITE: begin
                if (last_word_s) begin
`ifdef CHECKSUM_EN
                    state_d = CHK;
`else
                    state_d = DONE;
`endif
                end else begin
                    state_d = COLLECT;
                end
            end
            CHK: begin
`ifdef CHECKSUM_EN
                if (xfer_s) state_d = csum_ok_s ? DONE : ERROR;
                else        state_d = CHK;
`else
                state_d = ERROR;
`endif
            end
            DONE: begin
                if (Start) state_d = LEN;
                else       state_d = DONE;
            end
            ERROR: begin
                if (Start) state_d = LEN;
                else       state_d = ERROR;
            end
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs decoded from the next state so they are registered yet aligned with it.
    always_comb begin
        byte_ready_d = accepts_bytes(state_d);
        mem_write_d  = (state_d == WRITE);
        done_d       = (state_d == DONE);
        error_d      = (state_d == ERROR);
        cpu_hold_d   = (state_d != DONE);
    end

    // Datapath next values: word count, word index, write address/data latch.
    always_comb begin
        n_d    = n_q;
        idx_d  = idx_q;
        addr_d = addr_q;
        data_d = data_q;
        if ((state_q == LEN) && xfer_s) begin
            n_d   = Byte_in;
            idx_d = {IDX_W{1'b0}};
        end else if ((state_q == WRITE) && !last_word_s) begin
            idx_d = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
        end else begin
            n_d   = n_q;
            idx_d = idx_q;
        end
        // Latch on the 4th-byte edge so address and data are stable throughout WRITE.
        if (word_full_s) begin
            addr_d = ADDR_WIDTH'(idx_q);
            data_d = DATA_WIDTH'(word_next_s);
        end else begin
            addr_d = addr_q;
            data_d = data_q;
        end
    end

`ifdef CHECKSUM_EN
    // Running XOR over the length byte and every data byte of the session.
    always_comb begin
        csum_d = csum_q;
        if (asm_clear_s) begin
            csum_d = 8'd0;
        end else if (xfer_s && ((state_q == LEN) || (state_q == COLLECT))) begin
            csum_d = csum_q ^ Byte_in;
        end else begin
            csum_d = csum_q;
        end
    end

    // Checksum accumulator.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            csum_q <= 8'd0;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            n_q          <= 8'd0;
            idx_q        <= {IDX_W{1'b0}};
            addr_q       <= {ADDR_WIDTH{1'b0}};
            data_q       <= {DATA_WIDTH{1'b0}};
            byte_ready_q <= 1'b0;
            mem_write_q  <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            cpu_hold_q   <= 1'b1;
        end else begin
            n_q          <= n_d;
            idx_q        <= idx_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            byte_ready_q <= byte_ready_d;
            mem_write_q  <= mem_write_d;
            done_q       <= done_d;
            error_q      <= error_d;
            cpu_hold_q   <= cpu_hold_d;
        end
    end

    assign Byte_ready    = byte_ready_q;
    assign Mem_write     = mem_write_q;
    assign Write_address = addr_q;
    assign Write_data    = data_q;
    assign Done          = done_q;
    assign Error         = error_q;
    assign Cpu_hold      = cpu_hold_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: expected writes are queued at stimulus time and
// popped by a negedge monitor whenever Mem_write is seen. Honours CHECKSUM_EN.
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Start;
    logic [7:0]  Byte_in;
    logic        Byte_valid;
    logic        Byte_ready;
    logic [31:0] Write_address;
    logic [31:0] Write_data;
    logic        Mem_write;
    logic        Cpu_hold;
    logic        Done;
    logic        Error;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  tests = 0;
    int  fails = 0;

    instr_mem_loader #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_WORDS(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .Start         (Start),
        .Byte_in       (Byte_in),
        .Byte_valid    (Byte_valid),
        .Byte_ready    (Byte_ready),
        .Write_address (Write_address),
        .Write_data    (Write_data),
        .Mem_write     (Mem_write),
        .Cpu_hold      (Cpu_hold),
        .Done          (Done),
        .Error         (Error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Write monitor: every Mem_write must match the oldest queued expectation.
    always @(negedge clk) begin
        wr_t e;
        if (Mem_write === 1'b1) begin
            check("ready_low_in_write", {31'd0, Byte_ready}, 32'd0);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                         Write_address, Write_data);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", Write_address, e.addr);
                check("write_data", Write_data, e.data);
            end
        end
    end

    task automatic pulse_start();
        Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
    endtask

    // Present a byte (after an optional idle gap with junk data) until it is accepted.
    task automatic send_byte(input logic [7:0] b, input int gap);
        logic rdy;
        int   n;
        bit   got;
        Byte_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            Byte_in = 8'($urandom);
            @(posedge clk); #1;
        end
        Byte_in    = b;
        Byte_valid = 1'b1;
        n   = 0;
        got = 1'b0;
        while (!got && n < 50) begin
            rdy = Byte_ready;
            @(posedge clk); #1;
            got = rdy;
            n++;
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL byte_accept_timeout: byte 0x%0h not accepted, expected acceptance", b);
        end
    endtask

    task automatic do_load(input logic [7:0] n, input logic [31:0] w[$], input int maxgap,
                           input logic [7:0] csum_flip);
        logic [7:0] x;
        logic [7:0] b;
        pulse_start();
        x = n;
        send_byte(n, 0);
        foreach (w[i]) begin
            exp_q.push_back(wr_t'{32'(i), w[i]});
            for (int k = 0; k < 4; k++) begin
                b = 8'(w[i] >> (24 - 8 * k));
                x = x ^ b;
                send_byte(b, $urandom_range(0, maxgap));
            end
        end
`ifdef CHECKSUM_EN
        send_byte(x ^ csum_flip, 0);
`else
        x = x ^ csum_flip;
`endif
        Byte_valid = 1'b0;
    endtask

    // Wait (bounded) for Done or Error, then check the terminal status outputs.
    task automatic wait_status(input string name, input logic exp_done, input logic exp_err);
        int n;
        n = 0;
        while (Done !== 1'b1 && Error !== 1'b1 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        check({name, "_done"},  {31'd0, Done},       {31'd0, exp_done});
        check({name, "_error"}, {31'd0, Error},      {31'd0, exp_err});
        check({name, "_hold"},  {31'd0, Cpu_hold},   {31'd0, ~exp_done});
        check({name, "_ready"}, {31'd0, Byte_ready}, 32'd0);
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_ready"}, {31'd0, Byte_ready}, 32'd0);
        check({name, "_mw"},    {31'd0, Mem_write},  32'd0);
        check({name, "_addr"},  Write_address,       32'd0);
        check({name, "_data"},  Write_data,          32'd0);
        check({name, "_done"},  {31'd0, Done},       32'd0);
        check({name, "_error"}, {31'd0, Error},      32'd0);
        check({name, "_hold"},  {31'd0, Cpu_hold},   32'd1);
    endtask

    initial begin
        logic [31:0] w[$];
        rst_n      = 1'b0;
        Start      = 1'b0;
        Byte_valid = 1'b0;
        Byte_in    = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Two-word load, Byte_valid held high.
        w = '{32'h20080005, 32'h8C090004};
        do_load(8'd2, w, 0, 8'h00);
        wait_status("load2", 1'b1, 1'b0);

        // Zero length is rejected.
        pulse_start();
        send_byte(8'd0, 0);
        Byte_valid = 1'b0;
        wait_status("len0", 1'b0, 1'b1);

        // Start leaves ERROR; length NUM_WORDS+1 is rejected.
        pulse_start();
        check("err_restart_error", {31'd0, Error},      32'd0);
        check("err_restart_ready", {31'd0, Byte_ready}, 32'd1);
        send_byte(8'd33, 0);
        Byte_valid = 1'b0;
        wait_status("len33", 1'b0, 1'b1);

        // Three words with random valid gaps.
        w = '{32'h01234567, 32'h89ABCDEF, 32'hDEADBEEF};
        do_load(8'd3, w, 3, 8'h00);
        wait_status("gappy", 1'b1, 1'b0);

        // Reset after 6 bytes of an N=3 load: first word already written.
        pulse_start();
        send_byte(8'd3, 0);
        exp_q.push_back(wr_t'{32'd0, 32'h11223344});
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        send_byte(8'h55, 0);
        Byte_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_reset_values("midreset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        w = '{32'hAABBCCDD};
        do_load(8'd1, w, 0, 8'h00);
        wait_status("reload1", 1'b1, 1'b0);

        // Start mid-COLLECT, both with and without a simultaneous byte transfer.
        pulse_start();
        send_byte(8'd1, 0);
        exp_q.push_back(wr_t'{32'd0, 32'hAABBCCDD});
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        check("collect_ready", {31'd0, Byte_ready}, 32'd1);
        Byte_in    = 8'hCC;
        Byte_valid = 1'b1;
        Start      = 1'b1;
        @(posedge clk); #1;
        Byte_valid = 1'b0;
        @(posedge clk); #1;
        Start = 1'b0;
        send_byte(8'hDD, 0);
`ifdef CHECKSUM_EN
        send_byte(8'h01 ^ 8'hAA ^ 8'hBB ^ 8'hCC ^ 8'hDD, 0);
`endif
        Byte_valid = 1'b0;
        wait_status("midstart", 1'b1, 1'b0);

        // Start in DONE begins a reload.
        pulse_start();
        check("reload_done",  {31'd0, Done},       32'd0);
        check("reload_hold",  {31'd0, Cpu_hold},   32'd1);
        check("reload_ready", {31'd0, Byte_ready}, 32'd1);
        send_byte(8'd1, 0);
        exp_q.push_back(wr_t'{32'd0, 32'hCAFEF00D});
        send_byte(8'hCA, 0);
        send_byte(8'hFE, 0);
        send_byte(8'hF0, 0);
        send_byte(8'h0D, 0);
`ifdef CHECKSUM_EN
        send_byte(8'h01 ^ 8'hCA ^ 8'hFE ^ 8'hF0 ^ 8'h0D, 0);
`endif
        Byte_valid = 1'b0;
        wait_status("reload", 1'b1, 1'b0);

`ifdef CHECKSUM_EN
        // Checksum 0x05 accepted, 0x06 rejected after the word is written.
        w = '{32'h01020304};
        do_load(8'd1, w, 0, 8'h00);
        wait_status("csum_ok", 1'b1, 1'b0);
        do_load(8'd1, w, 0, 8'h03);
        wait_status("csum_bad", 1'b0, 1'b1);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
